// File: rtl/pram_arb_pkg.sv
// Shared types and constants for the program-RAM access arbiter.
package pram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LS    = 1'b1
  } owner_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/pram_access_arbiter_starve_counter.sv
// Saturating count of consecutive arbitrations fetch has lost to load/store.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/pram_access_arbiter.sv
// Shares one synchronous program-RAM port between fetch and load/store.
// Optional write protection below PROTECT_LIMIT: PRAM_ARB_WRITE_PROTECT_EN.
module pram_access_arbiter
  import pram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int STARVE_LIMIT  = 4,
  parameter logic [ADDRESS_WIDTH-1:0] PROTECT_LIMIT = 16'h0010
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_grant,
  output logic                     fetch_valid,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  input  logic                     ls_req,
  input  logic                     ls_rw,
  input  logic [ADDRESS_WIDTH-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0]    ls_wdata,
  output logic                     ls_grant,
  output logic                     ls_valid,
  output logic [DATA_WIDTH-1:0]    ls_rdata,
  output logic                     ls_fault,
  output logic                     ram_enable,
  output logic                     ram_rw,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic                     busy
);

  state_t                   state, state_next;
  owner_t                   owner_q;
  logic                     write_q, fault_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     arb_point, at_limit, protect_hit;
  logic                     grant_fetch, grant_ls, any_grant;

  // Gating on reset keeps every output low while reset is held.
  assign arb_point   = !reset && (state == IDLE || state == RESP);
  assign grant_fetch = arb_point && fetch_req && (!ls_req || at_limit);
  assign grant_ls    = arb_point && ls_req && !(fetch_req && at_limit);
  assign any_grant   = grant_fetch || grant_ls;

  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clock   (clock),
    .reset   (reset),
    .inc     (grant_ls && fetch_req),
    .clr     (grant_fetch || (arb_point && !fetch_req)),
    .at_limit(at_limit)
  );

`ifdef PRAM_ARB_WRITE_PROTECT_EN
  assign protect_hit = (ls_rw == RW_WRITE) && (ls_address < PROTECT_LIMIT);
`else
  logic unused_protect;
  assign protect_hit    = 1'b0;
  assign unused_protect = (ls_address < PROTECT_LIMIT);
`endif

  // NOTE: default assignment first so no path through always_comb infers a latch.
  always_comb begin
    state_next = IDLE;
    if (any_grant)           state_next = ISSUE;
    else if (state == ISSUE) state_next = RESP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= OWN_FETCH;
      write_q <= RW_READ;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (grant_ls) begin
        owner_q <= OWN_LS;
        write_q <= ls_rw;
        fault_q <= protect_hit;
        addr_q  <= ls_address;
        wdata_q <= ls_wdata;
      end else if (grant_fetch) begin
        owner_q <= OWN_FETCH;
        write_q <= RW_READ;
        fault_q <= 1'b0;
        addr_q  <= fetch_address;
      end
    end
  end

  assign fetch_grant = grant_fetch;
  assign ls_grant    = grant_ls;

  // A protected write goes out as a read so RAM contents are untouched.
  assign ram_enable  = (state == ISSUE);
  assign ram_rw      = ram_enable && write_q && !fault_q;
  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;

  assign fetch_valid = (state == RESP) && (owner_q == OWN_FETCH);
  assign ls_valid    = (state == RESP) && (owner_q == OWN_LS);
  assign fetch_data  = fetch_valid ? ram_rdata : '0;
  assign ls_rdata    = (ls_valid && !write_q) ? ram_rdata : '0;
  assign ls_fault    = ls_valid && fault_q;
  assign busy        = (state == ISSUE) || (state == RESP);

endmodule
